// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types for the memory stall controller: per-port state encoding and port indices.
package mem_stall_ctrl_pkg;

    localparam int unsigned MEM_PORT_STATE_W = 2;
    localparam int unsigned PORT_IMEM        = 0;
    localparam int unsigned PORT_DMEM        = 1;

    typedef enum logic [MEM_PORT_STATE_W-1:0] {
        port_idle = 2'b00,
        port_wait = 2'b01,
        port_drop = 2'b10
    } mem_port_state_t;

    // A port is busy while it owes the pipeline a response, live or stale.
    function automatic logic port_is_busy(input mem_port_state_t s);
        return (s == port_wait) || (s == port_drop);
    endfunction

endpackage

// File: rtl/mem_stall_ctrl_port_tracker.sv
// One memory port: outstanding-request FSM, live/stale response decode and
// optional wait-timeout counter (enabled by macro MEM_STALL_TIMEOUT_EN).
module mem_port_tracker
    import mem_stall_ctrl_pkg::*;
#(
    parameter bit FLUSH_EN = 1'b0
`ifdef MEM_STALL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned PORT_ID = 0
`endif
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req,
    input  logic            i_resp,
    input  logic            i_flush,
    input  logic            i_stall,
    output mem_port_state_t o_state,
    output logic            o_busy,
    output logic            o_use,
    output logic            o_drop,
    output logic            o_hold,
    output logic            o_timeout
);

    mem_port_state_t r_state;
    logic            w_flush_hit;
    logic            w_accept;

    assign w_flush_hit = i_flush & FLUSH_EN;
    assign w_accept    = i_req & ~i_stall;

    // Port FSM: a response retires the request, optionally chaining a new one in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= port_idle;
        end else begin
            case (r_state)
                port_idle: if (w_accept) r_state <= port_wait;
                port_wait: begin
                    if (i_resp)           r_state <= w_accept ? port_wait : port_idle;
                    else if (w_flush_hit) r_state <= port_drop;
                end
                port_drop: if (i_resp)    r_state <= w_accept ? port_wait : port_idle;
                default:                  r_state <= port_idle;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_busy  = port_is_busy(r_state);
    assign o_hold  = o_busy & ~i_resp;
    assign o_use   = (r_state == port_wait) & i_resp & ~w_flush_hit;
    assign o_drop  = i_resp & (((r_state == port_wait) & w_flush_hit) | (r_state == port_drop));

`ifdef MEM_STALL_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic              w_enter;
    logic              w_stay;

    assign w_enter = ((r_state == port_idle) & w_accept)
                   | (o_busy & i_resp & w_accept)
                   | ((r_state == port_wait) & ~i_resp & w_flush_hit);
    assign w_stay  = o_hold & ~w_enter;

    // Wait-cycle counter, restarted on each entry to wait/drop; timeout is sticky until reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_enter) begin
            r_wait_cnt <= '0;
        end else if (w_stay && (r_wait_cnt != WAIT_W'(TIMEOUT))) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                r_timeout <= 1'b1;
                $error("mem_port_tracker: port %0d timed out waiting for response", PORT_ID);
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/mem_stall_ctrl.sv
// Global pipeline stall from NUM_PORTS memory port trackers plus a saturating
// stall-cycle counter. Optional per-port timeout via macro MEM_STALL_TIMEOUT_EN.
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned          NUM_PORTS  = 2,
    parameter logic [NUM_PORTS-1:0] FLUSH_MASK = NUM_PORTS'(2'b01),
    parameter int unsigned          CNT_W      = 32,
    parameter int unsigned          TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   req_i,
    input  logic [NUM_PORTS-1:0]   resp_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic [NUM_PORTS-1:0]   busy_o,
    output logic [NUM_PORTS-1:0]   resp_use_o,
    output logic [NUM_PORTS-1:0]   resp_drop_o,
    output logic [2*NUM_PORTS-1:0] port_state_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic                   timeout_o
);

    mem_port_state_t        w_state [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_hold;
    logic [NUM_PORTS-1:0]   w_timeout;
    logic                   w_stall;
    logic [CNT_W-1:0]       r_stall_cnt;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mem_port_tracker #(
            .FLUSH_EN (FLUSH_MASK[p])
`ifdef MEM_STALL_TIMEOUT_EN
            ,
            .TIMEOUT  (TIMEOUT),
            .PORT_ID  (p)
`endif
        ) u_trk (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_req     (req_i[p]),
            .i_resp    (resp_i[p]),
            .i_flush   (flush_i),
            .i_stall   (w_stall),
            .o_state   (w_state[p]),
            .o_busy    (busy_o[p]),
            .o_use     (resp_use_o[p]),
            .o_drop    (resp_drop_o[p]),
            .o_hold    (w_hold[p]),
            .o_timeout (w_timeout[p])
        );

        assign port_state_o[2*p +: 2] = w_state[p];
    end

    // Any port still owed a response holds the whole pipeline.
    assign w_stall   = |w_hold;
    assign stall_o   = w_stall;
    assign timeout_o = |w_timeout;

    // Saturating count of stalled cycles since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_mem_stall_ctrl;
    import mem_stall_ctrl_pkg::*;

    localparam int unsigned NP    = 2;
    localparam int unsigned CW    = 3;
`ifdef MEM_STALL_TIMEOUT_EN
    localparam bit          TO_EN = 1'b1;
`else
    localparam bit          TO_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [14:0] v;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req_i = '0;
    logic [NP-1:0]   resp_i = '0;
    logic            flush_i = 1'b0;
    logic            stall_o;
    logic [NP-1:0]   busy_o;
    logic [NP-1:0]   resp_use_o;
    logic [NP-1:0]   resp_drop_o;
    logic [2*NP-1:0] port_state_o;
    logic [CW-1:0]   stall_cnt_o;
    logic            timeout_o;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mem_stall_ctrl #(
        .NUM_PORTS  (NP),
        .FLUSH_MASK (2'b01),
        .CNT_W      (CW),
        .TIMEOUT    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .resp_i       (resp_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .resp_use_o   (resp_use_o),
        .resp_drop_o  (resp_drop_o),
        .port_state_o (port_state_o),
        .stall_cnt_o  (stall_cnt_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the queued expectation for this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {stall_o, busy_o, resp_use_o, resp_drop_o, port_state_o, stall_cnt_o, timeout_o};
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s: got stall=%b busy=%b use=%b drop=%b state=%b cnt=%0d to=%b, expected stall=%b busy=%b use=%b drop=%b state=%b cnt=%0d to=%b",
                         e.name, act[14], act[13:12], act[11:10], act[9:8], act[7:4], act[3:1], act[0],
                         e.v[14], e.v[13:12], e.v[11:10], e.v[9:8], e.v[7:4], e.v[3:1], e.v[0]);
            end
        end
    end

    task automatic push_exp(input string name, input logic st, input logic [1:0] busy,
                            input logic [1:0] use_v, input logic [1:0] drop, input logic [3:0] state,
                            input logic [2:0] cnt, input logic to);
        exp_t e;
        e.name = name;
        e.v    = {st, busy, use_v, drop, state, cnt, to};
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs just after the edge and queue that cycle's expected outputs.
    task automatic step(input logic [1:0] req, input logic [1:0] resp, input logic flush,
                        input string name, input logic st, input logic [1:0] busy,
                        input logic [1:0] use_v, input logic [1:0] drop, input logic [3:0] state,
                        input logic [2:0] cnt, input logic to);
        @(posedge clk);
        #1;
        req_i   = req;
        resp_i  = resp;
        flush_i = flush;
        push_exp(name, st, busy, use_v, drop, state, cnt, to);
    endtask

    // Assert reset between edges; everything must read 0 while it is held.
    task automatic rst_pulse(input string name);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        req_i   = '0;
        resp_i  = '0;
        flush_i = 1'b0;
        push_exp(name, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] c;
        logic       to;

        // Reset then idle
        rst_pulse("reset_hold");
        for (int i = 0; i < 10; i++)
            step(2'b00, 2'b00, 1'b0, "idle", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);

        // imem latency
        rst_pulse("reset_imem");
        step(2'b01, 2'b00, 1'b0, "imem_c1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        step(2'b00, 2'b00, 1'b0, "imem_c2", 1, 2'b01, 2'b00, 2'b00, 4'b0001, 3'd0, 0);
        step(2'b00, 2'b00, 1'b0, "imem_c3", 1, 2'b01, 2'b00, 2'b00, 4'b0001, 3'd1, 0);
        step(2'b00, 2'b01, 1'b0, "imem_c4", 0, 2'b01, 2'b01, 2'b00, 4'b0001, 3'd2, 0);
        step(2'b00, 2'b00, 1'b0, "imem_c5", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd2, 0);

        // Dual outstanding
        rst_pulse("reset_dual");
        step(2'b11, 2'b00, 1'b0, "dual_c1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        step(2'b00, 2'b00, 1'b0, "dual_c2", 1, 2'b11, 2'b00, 2'b00, 4'b0101, 3'd0, 0);
        step(2'b00, 2'b10, 1'b0, "dual_c3", 1, 2'b11, 2'b10, 2'b00, 4'b0101, 3'd1, 0);
        step(2'b00, 2'b00, 1'b0, "dual_c4", 1, 2'b01, 2'b00, 2'b00, 4'b0001, 3'd2, 0);
        step(2'b00, 2'b01, 1'b0, "dual_c5", 0, 2'b01, 2'b01, 2'b00, 4'b0001, 3'd3, 0);
        step(2'b00, 2'b00, 1'b0, "dual_c6", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd3, 0);

        // Flush squash: port 0 parks in drop until its stale response arrives
        rst_pulse("reset_flush");
        step(2'b01, 2'b00, 1'b0, "flush_c1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        step(2'b00, 2'b00, 1'b1, "flush_c2", 1, 2'b01, 2'b00, 2'b00, 4'b0001, 3'd0, 0);
        step(2'b00, 2'b00, 1'b0, "flush_c3", 1, 2'b01, 2'b00, 2'b00, 4'b0010, 3'd1, 0);
        step(2'b00, 2'b00, 1'b1, "flush_c4", 1, 2'b01, 2'b00, 2'b00, 4'b0010, 3'd2, 0);
        step(2'b00, 2'b00, 1'b0, "flush_c5", 1, 2'b01, 2'b00, 2'b00, 4'b0010, 3'd3, 0);
        step(2'b00, 2'b01, 1'b0, "flush_c6", 0, 2'b01, 2'b00, 2'b01, 4'b0010, 3'd4, 0);
        step(2'b00, 2'b00, 1'b0, "flush_c7", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd4, 0);

        // Coincident flush+resp with back-to-back req on imem
        rst_pulse("reset_b2b_imem");
        step(2'b01, 2'b00, 1'b0, "b2bi_c1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        step(2'b00, 2'b00, 1'b0, "b2bi_c2", 1, 2'b01, 2'b00, 2'b00, 4'b0001, 3'd0, 0);
        step(2'b01, 2'b01, 1'b1, "b2bi_c3", 0, 2'b01, 2'b00, 2'b01, 4'b0001, 3'd1, 0);
        step(2'b00, 2'b00, 1'b0, "b2bi_c4", 1, 2'b01, 2'b00, 2'b00, 4'b0001, 3'd1, 0);
        step(2'b00, 2'b01, 1'b0, "b2bi_c5", 0, 2'b01, 2'b01, 2'b00, 4'b0001, 3'd2, 0);
        step(2'b00, 2'b00, 1'b0, "b2bi_c6", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd2, 0);

        // Same on dmem, which is not flushable: response stays live, flush ignored
        rst_pulse("reset_b2b_dmem");
        step(2'b10, 2'b00, 1'b0, "b2bd_c1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        step(2'b00, 2'b00, 1'b0, "b2bd_c2", 1, 2'b10, 2'b00, 2'b00, 4'b0100, 3'd0, 0);
        step(2'b10, 2'b10, 1'b1, "b2bd_c3", 0, 2'b10, 2'b10, 2'b00, 4'b0100, 3'd1, 0);
        step(2'b00, 2'b00, 1'b0, "b2bd_c4", 1, 2'b10, 2'b00, 2'b00, 4'b0100, 3'd1, 0);
        step(2'b00, 2'b00, 1'b1, "b2bd_c5", 1, 2'b10, 2'b00, 2'b00, 4'b0100, 3'd2, 0);
        step(2'b00, 2'b00, 1'b0, "b2bd_c6", 1, 2'b10, 2'b00, 2'b00, 4'b0100, 3'd3, 0);
        step(2'b00, 2'b10, 1'b0, "b2bd_c7", 0, 2'b10, 2'b10, 2'b00, 4'b0100, 3'd4, 0);
        step(2'b00, 2'b00, 1'b0, "b2bd_c8", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd4, 0);

        // Request held during stall is only taken once the stall clears; idle flush is a no-op
        rst_pulse("reset_hold_req");
        step(2'b01, 2'b00, 1'b0, "hold_c1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        step(2'b10, 2'b00, 1'b0, "hold_c2", 1, 2'b01, 2'b00, 2'b00, 4'b0001, 3'd0, 0);
        step(2'b10, 2'b01, 1'b0, "hold_c3", 0, 2'b01, 2'b01, 2'b00, 4'b0001, 3'd1, 0);
        step(2'b00, 2'b00, 1'b0, "hold_c4", 1, 2'b10, 2'b00, 2'b00, 4'b0100, 3'd1, 0);
        step(2'b00, 2'b10, 1'b0, "hold_c5", 0, 2'b10, 2'b10, 2'b00, 4'b0100, 3'd2, 0);
        step(2'b00, 2'b00, 1'b1, "idle_flush", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd2, 0);
        step(2'b00, 2'b00, 1'b0, "idle_after_flush", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd2, 0);

        // Long wait: counter saturates at 7, timeout (when built in) after 8 waiting cycles
        rst_pulse("reset_long");
        step(2'b01, 2'b00, 1'b0, "long_c1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        for (int k = 2; k <= 11; k++) begin
            c  = (k - 2 > 7) ? 3'd7 : 3'(k - 2);
            to = TO_EN && (k >= 10);
            step(2'b00, 2'b00, 1'b0, "long_wait", 1, 2'b01, 2'b00, 2'b00, 4'b0001, c, to);
        end
        step(2'b00, 2'b01, 1'b0, "long_resp", 0, 2'b01, 2'b01, 2'b00, 4'b0001, 3'd7, TO_EN);
        step(2'b00, 2'b00, 1'b0, "long_sticky", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd7, TO_EN);

        // Async reset mid-wait, then a late response must be ignored
        step(2'b01, 2'b00, 1'b0, "mid_c1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd7, TO_EN);
        step(2'b00, 2'b00, 1'b0, "mid_c2", 1, 2'b01, 2'b00, 2'b00, 4'b0001, 3'd7, TO_EN);
        rst_pulse("reset_mid_wait");
        step(2'b00, 2'b01, 1'b0, "late_resp", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        step(2'b00, 2'b10, 1'b0, "late_resp_p1", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);
        step(2'b00, 2'b00, 1'b0, "post_reset_idle", 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'd0, 0);

        // Drain: every queued expectation must have been consumed within a few cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        if (PORT_IMEM == PORT_DMEM) begin
            failures++;
            $display("FAIL port_index: imem=%0d dmem=%0d, expected distinct", PORT_IMEM, PORT_DMEM);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Parametrised successor to the fixed two-port idle/wait_imem/wait_dmem stall FSM.
- Tracks one outstanding request on each of NUM_PORTS memory ports and produces the global pipeline stall.
- Adds flush-aware squashing of stale responses and a stall-cycle counter.
- Sits beside the stage registers; every stage register advances only when stall_o is low.

Parameters:
- NUM_PORTS, 2, number of tracked memory ports (port 0 = imem, port 1 = dmem by convention).
- FLUSH_MASK, 2'b01, bit p set: port p's outstanding request is squashed by flush_i.
- CNT_W, 32, width of the stall-cycle counter.
- TIMEOUT, 1024, maximum wait cycles before timeout is flagged (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_i  in  NUM_PORTS  request issued on port p this cycle; accepted only when stall_o=0
- resp_i  in  NUM_PORTS  memory response valid on port p
- flush_i  in  1  pipeline redirect (branch/jump taken)
- stall_o  out  1  hold all stage registers
- busy_o  out  NUM_PORTS  port p is in port_wait or port_drop
- resp_use_o  out  NUM_PORTS  resp_i[p] is live data and must be consumed
- resp_drop_o  out  NUM_PORTS  resp_i[p] is stale and must be discarded
- port_state_o  out  2*NUM_PORTS  packed mem_port_state_t per port, for debug/monitor
- stall_cnt_o  out  CNT_W  number of cycles with stall_o=1 since reset
- timeout_o  out  1  sticky timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset, asynchronous on rst=1:
  - All ports go to port_idle; stall_cnt_o=0; timeout_o=0.
  - All outputs read 0 while rst is held.
  - Reset mid-wait abandons the request; a later resp_i in port_idle is ignored: use=0, drop=0.
- Per-port FSM, states port_idle, port_wait, port_drop:
  - port_idle: req_i[p] & ~stall_o -> port_wait. resp_i is ignored.
  - port_wait, resp_i=1, flush_i=0 or FLUSH_MASK[p]=0:
    - resp_use_o[p]=1.
    - Next state is port_wait if req_i[p] & ~stall_o (back-to-back), else port_idle.
  - port_wait, resp_i=1, flush_i=1, FLUSH_MASK[p]=1:
    - resp_drop_o[p]=1; resp_use_o[p]=0.
    - Next state follows the same req rule as the unflushed case.
  - port_wait, resp_i=0, flush_i=1, FLUSH_MASK[p]=1 -> port_drop.
  - port_wait, resp_i=0 otherwise: hold.
  - port_drop, resp_i=1:
    - resp_drop_o[p]=1.
    - Next state is port_wait if req_i[p] & ~stall_o, else port_idle.
  - port_drop, resp_i=0: hold. flush_i has no further effect.
- stall_o is combinational: OR over p of (port_wait & ~resp_i) | (port_drop & ~resp_i).
  - A response therefore releases the stall in the same cycle; latency from last resp to advance is 0 cycles.
- req_i while stall_o=1 is not accepted. Upstream holds req_i until a cycle with stall_o=0.
- Only one request may be outstanding per port. Memory returns resp no earlier than the cycle after acceptance.
- resp_use_o and resp_drop_o are mutually exclusive and only asserted when resp_i[p]=1.
- stall_cnt_o increments every cycle stall_o=1 and saturates at all-ones; it does not wrap.
- flush_i on a port in port_idle, or on a port whose FLUSH_MASK bit is 0: no effect.

Optional Feature:
- Macro: MEM_STALL_TIMEOUT_EN.
- Defined:
  - Per-port wait counter, cleared on entry to port_wait/port_drop, increments while held there.
  - When any counter reaches TIMEOUT, timeout_o sets and stays set until rst.
  - Simulation $error naming the port.
  - Stall behaviour is unchanged.
- Undefined: no counters; timeout_o tied 0.

Decomposition:
- Shared package rv32i_types gains:
  - typedef enum logic [1:0] mem_port_state_t {port_idle=2'b00, port_wait=2'b01, port_drop=2'b10}, superseding stall_state.
  - localparam PORT_IMEM=0, PORT_DMEM=1.
- Sub-module mem_port_tracker: one port's FSM, use/drop decode, and optional timeout counter. Instantiated NUM_PORTS times in a generate loop.
- The top level holds the stall OR-reduction and the stall counter.

Test Plan:
- Reset then idle: rst pulse, no req for 10 cycles -> stall_o=0, stall_cnt_o=0, all port_state_o=port_idle.
- imem latency: req_i=2'b01 at cycle 1, resp_i[0] at cycle 4 -> stall_o=1 in cycles 2-3, 0 in cycle 4; resp_use_o[0]=1 in cycle 4; stall_cnt_o=2.
- Dual outstanding: req_i=2'b11 at cycle 1; resp_i[1] at 3; resp_i[0] at 5:
  - stall_o=1 in cycles 2-4, 0 in cycle 5; stall_cnt_o=3.
  - busy_o=2'b01 in cycle 4.
- Flush squash: imem req at cycle 1, flush_i at cycle 2, resp_i[0] at cycle 6:
  - port 0 is port_drop in cycles 3-6.
  - resp_drop_o[0]=1 and resp_use_o[0]=0 at cycle 6; stall_o=0 at cycle 6.
- Flush with coincident resp plus back-to-back req: port 0 in wait, cycle with resp_i[0]=1, flush_i=1, req_i[0]=1 -> resp_drop_o[0]=1, next state port_wait. Repeat with FLUSH_MASK bit 1 = 0 on dmem -> resp_use_o[1]=1.
- Async reset mid-wait plus timeout (MEM_STALL_TIMEOUT_EN, TIMEOUT=8):
  - Request with no response for 8 cycles -> timeout_o=1, sticky.
  - rst asserted between clock edges -> outputs 0 immediately.
  - A later resp_i is ignored: use=0, drop=0.
